// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//   Round-robin arbiter and sequencer for the shared packet bus. One request
//   is granted at a time. The winner's packet is captured and its FIFO is
//   popped. The destination ID is decoded into per-port push strobes, and the
//   packet is then driven on the bus for one cycle. If the destination does
//   not resolve to at least one port, the packet is dropped and a saturating
//   drop counter advances.
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      asynchronous reset, active low
//   req_i        per-driver request, packet valid on pkt_in_i slice
//   pkt_in_i     packets, driver i at [i*PCKG +: PCKG]
//   pop_o        one-hot 1-cycle pulse, granted driver's packet consumed
//   bus_valid_o  bus_data_o valid this cycle
//   bus_data_o   packet on the bus (holds last delivered packet)
//   bus_src_o    index of the driver owning the bus (holds last value)
//   push_o       destination strobes, valid with bus_valid_o
//   drop_o       1-cycle pulse, captured packet discarded
//   drop_cnt_o   saturating count of dropped packets
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | wait for any request, arbitrate and capture the winner's packet
// GRANT | pop the winner's FIFO, decode the destination mask
// SEND  | drive bus + push strobes, or pulse drop when the mask is empty
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter int          DRIVERS = 4,
  parameter int          PCKG    = 16,
  parameter logic [7:0]  BROD    = 8'hFF,
  localparam int         IDX_W   = $clog2(DRIVERS)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [DRIVERS-1:0]        req_i,
  input  logic [DRIVERS*PCKG-1:0]   pkt_in_i,
  output logic [DRIVERS-1:0]        pop_o,
  output logic                      bus_valid_o,
  output logic [PCKG-1:0]           bus_data_o,
  output logic [IDX_W-1:0]          bus_src_o,
  output logic [DRIVERS-1:0]        push_o,
  output logic                      drop_o,
  output logic [7:0]                drop_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DRIVERS - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     src_q, src_d;
  logic [PCKG-1:0]      pkt_q, pkt_d;
  logic [DRIVERS-1:0]   mask_q, mask_d;
  logic [PCKG-1:0]      bus_data_q, bus_data_d;
  logic [IDX_W-1:0]     bus_src_q, bus_src_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [PCKG-1:0]      win_pkt;
  logic [7:0]           dest_id;
  logic [DRIVERS-1:0]   dest_mask;

  // -------------------------------------------------------------------------
  // Round-robin search: start just after the last winner and wrap, so a
  // driver holding its request waits until every other requester is served.
  // -------------------------------------------------------------------------
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= DRIVERS; i++) begin
      cand = int'(last_grant_q) + i;
      if (cand >= DRIVERS) begin
        cand = cand - DRIVERS;
      end
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Packet mux for the winner. A loop avoids a variable-width part select.
  always_comb begin
    win_pkt = '0;
    for (int i = 0; i < DRIVERS; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_pkt = pkt_in_i[i*PCKG +: PCKG];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Destination decode from the captured packet. Broadcast wins over the
  // unicast range check. A packet addressed to its own source is treated as
  // undeliverable.
  // -------------------------------------------------------------------------
  assign dest_id = pkt_q[PCKG-1 -: 8];

  always_comb begin
    dest_mask = '0;
    if (dest_id == BROD) begin
      dest_mask        = '1;
      dest_mask[src_q] = 1'b0;
    end else if ((int'(dest_id) < DRIVERS) && (int'(dest_id) != int'(src_q))) begin
      dest_mask[dest_id[IDX_W-1:0]] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_SEND;
      ST_SEND:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    last_grant_d = last_grant_q;
    src_d        = src_q;
    pkt_d        = pkt_q;
    mask_d       = mask_q;
    bus_data_d   = bus_data_q;
    bus_src_d    = bus_src_q;
    drop_cnt_d   = drop_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          pkt_d        = win_pkt;
          src_d        = win_idx;
          last_grant_d = win_idx;
        end
      end
      ST_GRANT: begin
        mask_d = dest_mask;
        // The bus registers only load on delivery, so they hold the last
        // delivered packet through drops and idle periods.
        if (dest_mask != '0) begin
          bus_data_d = pkt_q;
          bus_src_d  = src_q;
        end else if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_IDX;
      src_q        <= '0;
      pkt_q        <= '0;
      mask_q       <= '0;
      bus_data_q   <= '0;
      bus_src_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      pkt_q        <= pkt_d;
      mask_q       <= mask_d;
      bus_data_q   <= bus_data_d;
      bus_src_q    <= bus_src_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Strobes decode from the registered state, so an async reset
  // clears them in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    pop_o = '0;
    if (state_q == ST_GRANT) begin
      pop_o[src_q] = 1'b1;
    end
  end

  always_comb begin
    push_o      = '0;
    bus_valid_o = 1'b0;
    drop_o      = 1'b0;
    if (state_q == ST_SEND) begin
      push_o      = mask_q;
      bus_valid_o = (mask_q != '0);
      drop_o      = (mask_q == '0);
    end
  end

  assign bus_data_o = bus_data_q;
  assign bus_src_o  = bus_src_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] pkt_in;
  logic [3:0]  pop;
  logic        bus_valid;
  logic [15:0] bus_data;
  logic [1:0]  bus_src;
  logic [3:0]  push;
  logic        drop;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  bus_rr_arbiter #(.DRIVERS(4), .PCKG(16), .BROD(8'hFF)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .pkt_in_i    (pkt_in),
    .pop_o       (pop),
    .bus_valid_o (bus_valid),
    .bus_data_o  (bus_data),
    .bus_src_o   (bus_src),
    .push_o      (push),
    .drop_o      (drop),
    .drop_cnt_o  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    req    = 4'b0000;
    pkt_in = '0;
    #3;
    checks++;
    if (pop !== 4'b0000 || push !== 4'b0000 || bus_valid !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes pop=%b push=%b valid=%b drop=%b expected all 0", pop, push, bus_valid, drop);
    end
    checks++;
    if (bus_data !== 16'h0000 || bus_src !== 2'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs data=%h src=%0d cnt=%0d expected 0", bus_data, bus_src, drop_cnt);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_unicast();
    req    = 4'b0001;
    pkt_in = {48'h0, 16'h01AB};
    tick();
    checks++;
    if (pop !== 4'b0001 || bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL unicast_pop pop=%b valid=%b expected 0001/0", pop, bus_valid);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (bus_valid !== 1'b1 || bus_data !== 16'h01AB || bus_src !== 2'd0 || push !== 4'b0010 || pop !== 4'b0000) begin
      errors++;
      $display("FAIL unicast_send valid=%b data=%h src=%0d push=%b pop=%b expected 1/01ab/0/0010/0000",
               bus_valid, bus_data, bus_src, push, pop);
    end
    tick();
    checks++;
    if (bus_valid !== 1'b0 || push !== 4'b0000 || bus_data !== 16'h01AB) begin
      errors++;
      $display("FAIL unicast_after valid=%b push=%b data=%h expected 0/0000/01ab", bus_valid, push, bus_data);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop;
    int         order [5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    pkt_in = {16'h0043, 16'h0332, 16'h0221, 16'h0110};
    req    = 4'b1111;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_pop = 4'b0000;
      if (k % 3 == 1) exp_pop[order[(k-1)/3]] = 1'b1;
      checks++;
      if (pop !== exp_pop) begin
        errors++;
        $display("FAIL rr_pop cycle=%0d pop=%b expected %b", k, pop, exp_pop);
      end
      if (k % 3 == 2) begin
        checks++;
        if (bus_valid !== 1'b1 || bus_src !== 2'(order[(k-2)/3])) begin
          errors++;
          $display("FAIL rr_src cycle=%0d valid=%b src=%0d expected 1/%0d", k, bus_valid, bus_src, order[(k-2)/3]);
        end
      end
      if (k == 13) req = 4'b0000;
    end
  endtask

  task automatic test_broadcast();
    req    = 4'b0100;
    pkt_in = {16'h0, 16'hFF55, 32'h0};
    tick();
    checks++;
    if (pop !== 4'b0100) begin
      errors++;
      $display("FAIL bcast_pop pop=%b expected 0100", pop);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (bus_valid !== 1'b1 || push !== 4'b1011 || bus_src !== 2'd2 || bus_data !== 16'hFF55) begin
      errors++;
      $display("FAIL bcast_send valid=%b push=%b src=%0d data=%h expected 1/1011/2/ff55",
               bus_valid, push, bus_src, bus_data);
    end
    tick();
  endtask

  task automatic drop_one(input logic [15:0] p, input logic [7:0] exp_cnt);
    req    = 4'b0010;
    pkt_in = {32'h0, p, 16'h0};
    tick();
    checks++;
    if (pop !== 4'b0010) begin
      errors++;
      $display("FAIL drop_pop pkt=%h pop=%b expected 0010", p, pop);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (drop !== 1'b1 || bus_valid !== 1'b0 || push !== 4'b0000 || bus_data !== 16'hFF55 || bus_src !== 2'd2) begin
      errors++;
      $display("FAIL drop_send pkt=%h drop=%b valid=%b push=%b data=%h src=%0d expected 1/0/0000/ff55/2",
               p, drop, bus_valid, push, bus_data, bus_src);
    end
    tick();
    checks++;
    if (drop !== 1'b0 || drop_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL drop_cnt pkt=%h drop=%b cnt=%0d expected 0/%0d", p, drop, drop_cnt, exp_cnt);
    end
  endtask

  task automatic test_drop();
    drop_one(16'h0500, 8'd1);
    drop_one(16'h0100, 8'd2);
    req    = 4'b0010;
    pkt_in = {32'h0, 16'h0500, 16'h0};
    for (int t = 0; t < 252 * 3; t++) tick();
    checks++;
    if (drop_cnt !== 8'd254) begin
      errors++;
      $display("FAIL drop_cnt_254 cnt=%0d expected 254", drop_cnt);
    end
    for (int t = 0; t < 46 * 3; t++) tick();
    req = 4'b0000;
    tick();
    tick();
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_cnt_sat cnt=%0d expected 255", drop_cnt);
    end
  endtask

  task automatic test_reset_mid_send();
    req    = 4'b0001;
    pkt_in = {48'h0, 16'h02CD};
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (bus_valid !== 1'b1 || push !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_pre valid=%b push=%b expected 1/0100", bus_valid, push);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (pop !== 4'b0000 || push !== 4'b0000 || bus_valid !== 1'b0 || drop !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midrst_clear pop=%b push=%b valid=%b drop=%b cnt=%0d expected all 0",
               pop, push, bus_valid, drop, drop_cnt);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (pop !== 4'b0000 || push !== 4'b0000 || bus_valid !== 1'b0 || drop !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet cycle=%0d pop=%b push=%b valid=%b drop=%b expected all 0",
                 k, pop, push, bus_valid, drop);
      end
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    req    = 4'b1001;
    pkt_in = {16'h0277, 32'h0, 16'h0155};
    tick();
    checks++;
    if (pop !== 4'b0001) begin
      errors++;
      $display("FAIL prio_first pop=%b expected 0001", pop);
    end
    req = 4'b1000;
    tick();
    checks++;
    if (bus_valid !== 1'b1 || bus_src !== 2'd0 || push !== 4'b0010 || bus_data !== 16'h0155) begin
      errors++;
      $display("FAIL prio_send0 valid=%b src=%0d push=%b data=%h expected 1/0/0010/0155",
               bus_valid, bus_src, push, bus_data);
    end
    tick();
    tick();
    checks++;
    if (pop !== 4'b1000) begin
      errors++;
      $display("FAIL prio_second pop=%b expected 1000", pop);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (bus_valid !== 1'b1 || bus_src !== 2'd3 || push !== 4'b0100 || bus_data !== 16'h0277) begin
      errors++;
      $display("FAIL prio_send3 valid=%b src=%0d push=%b data=%h expected 1/3/0100/0277",
               bus_valid, bus_src, push, bus_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_round_robin();
    test_broadcast();
    test_drop();
    test_reset_mid_send();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
